// File: rtl/arc4_pkg.sv
//==============================================================================
// arc4_pkg : shared types and constants for the ARC4 state-memory blocks
// Rev 1.0
//==============================================================================
`default_nettype none

package arc4_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int IDX_W     = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } init_state_t;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/arc4_task1_if.sv
//==============================================================================
// arc4_task1_if : single-port state RAM bus shared by the ARC4 engines
// Rev 1.0
//==============================================================================
`default_nettype none

interface arc4_task1_if;
    import arc4_pkg::*;

    addr_t addr;
    byte_t wrdata;
    logic  wren;
    byte_t q;

    modport master (output addr, output wrdata, output wren, input  q);
    modport slave  (input  addr, input  wrdata, input  wren, output q);
    modport monitor(input  addr, input  wrdata, input  wren, input  q);

endinterface

`default_nettype wire

// File: rtl/init.sv
//==============================================================================
// init : fills the state RAM with S[i] = i after an en strobe (rdy/en protocol)
// Rev 1.0
//==============================================================================
`default_nettype none

module init
    import arc4_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    en_i,
    output logic         rdy_o,
    output logic         done_o,
    arc4_task1_if.master mem
);

    init_state_t      state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
        end
    end

    // The extra index bit marks "past the last entry": one quiet cycle in FILL,
    // then DONE, so the counter never wraps back onto S[0].
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        rdy_o      = 1'b1;
        done_o     = 1'b0;
        mem.wren   = 1'b0;
        mem.addr   = i_q[ADDR_W-1:0];
        mem.wrdata = i_q[DATA_W-1:0];

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = FILL;
                    i_d     = '0;
                end
            end
            FILL: begin
                rdy_o = 1'b0;
                if (i_q[IDX_W-1]) begin
                    state_d = DONE;
                end else begin
                    mem.wren = 1'b1;
                    i_d      = i_q + IDX_W'(1);
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (en_i) begin
                    state_d = FILL;
                    i_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/s_mem.sv
//==============================================================================
// s_mem : 256 x 8 single-port state RAM, synchronous write, registered read
// Rev 1.0
//==============================================================================
`default_nettype none

module s_mem
    import arc4_pkg::*;
(
    input  wire logic   clk,
    arc4_task1_if.slave mem
);

    byte_t mem_data [MEM_DEPTH];
    byte_t q_q;

    // Read-before-write: a same-address access returns the previous contents.
    always_ff @(posedge clk) begin
        if (mem.wren) begin
            mem_data[mem.addr] <= mem.wrdata;
        end
        q_q <= mem_data[mem.addr];
    end

    assign mem.q = q_q;

endmodule

`default_nettype wire

// File: rtl/arc4_task1.sv
//==============================================================================
// arc4_task1 : DE1-SoC top for ARC4 step 1 - self-started S[i] = i fill
// Rev 1.0
//==============================================================================
`default_nettype none

module arc4_task1
    import arc4_pkg::*;
(
    input  wire logic       CLOCK_50,
    input  wire logic [3:0] KEY,
    input  wire logic [9:0] SW,
    output logic      [6:0] HEX0,
    output logic      [6:0] HEX1,
    output logic      [6:0] HEX2,
    output logic      [6:0] HEX3,
    output logic      [6:0] HEX4,
    output logic      [6:0] HEX5,
    output logic      [9:0] LEDR
);

    logic rst_n;
    logic en;
    logic rdy;
    logic done;
    logic en_q, en_d;
    logic started_q, started_d;

    arc4_task1_if bus();

    assign rst_n = KEY[3];

    // One strobe per reset: fires on the first edge that sees the engine ready.
    always_comb begin
        en_d      = ~started_q & rdy;
        started_d = started_q | en_d;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            started_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            started_q <= started_d;
        end
    end

    assign en = en_q;

    init u_init (
        .clk    (CLOCK_50),
        .rst_n  (rst_n),
        .en_i   (en),
        .rdy_o  (rdy),
        .done_o (done),
        .mem    (bus.master)
    );

    s_mem s (
        .clk (CLOCK_50),
        .mem (bus.slave)
    );

    assign HEX0 = HEX_BLANK;
    assign HEX1 = HEX_BLANK;
    assign HEX2 = HEX_BLANK;
    assign HEX3 = HEX_BLANK;
    assign HEX4 = HEX_BLANK;
    assign HEX5 = HEX_BLANK;
    assign LEDR = {8'd0, ~rdy, done};

    // Reserved inputs and the read port are consumed by later ARC4 steps.
    wire w_unused = &{1'b0, KEY[2:0], SW, bus.q};

endmodule

`default_nettype wire

// File: tb/tb_arc4_task1.sv
//==============================================================================
// tb_arc4_task1 : self-checking bench for the ARC4 step-1 state fill
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_arc4_task1;
    import arc4_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int    n_checks = 0;
    int    n_fail   = 0;
    byte_t exp_mem [MEM_DEPTH];

    arc4_task1 dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    arc4_task1_if mon();
    assign mon.addr   = dut.bus.addr;
    assign mon.wrdata = dut.bus.wrdata;
    assign mon.wren   = dut.bus.wren;
    assign mon.q      = dut.bus.q;

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reserved switches toggle freely; they must never disturb the fill.
    initial begin
        SW = '0;
        forever begin
            @(negedge CLOCK_50);
            SW = 10'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_static();
        check_eq("hex_blank", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{HEX_BLANK}});
        check_eq("ledr_hi", 64'(LEDR[9:2]), 64'd0);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (dut.s.mem_data[i] !== exp_mem[i]) bad++;
        end
        check_eq({tag, "_bad_entries"}, 64'(bad), 64'd0);
        check_eq({tag, "_s0"},   64'(dut.s.mem_data[0]),   64'(exp_mem[0]));
        check_eq({tag, "_s128"}, 64'(dut.s.mem_data[128]), 64'(exp_mem[128]));
        check_eq({tag, "_s255"}, 64'(dut.s.mem_data[255]), 64'(exp_mem[255]));
    endtask

    // Start by forcing en for one cycle; checks every write cycle and the done timing.
    task automatic forced_fill(input bit chk_q, input bit from_reset);
        force dut.en = 1'b1;
        if (from_reset) KEY[3] = 1'b1;
        @(posedge CLOCK_50);
        #1;
        release dut.en;
        @(negedge CLOCK_50);
        check_eq("busy_after_en", 64'(LEDR[1:0]), 64'b10);
        for (int j = 0; j < MEM_DEPTH; j++) begin
            check_eq("fill_bus", {mon.wren, mon.addr, mon.wrdata}, {1'b1, 8'(j), 8'(j)});
            if (chk_q) check_eq("read_old", 64'(mon.q), 64'((j == 0) ? 0 : j - 1));
            @(negedge CLOCK_50);
        end
        check_eq("tail_wren", 64'(mon.wren), 64'd0);
        check_eq("tail_not_done", 64'(LEDR[1:0]), 64'b10);
        @(negedge CLOCK_50);
        check_eq("done_k257", 64'(LEDR[1:0]), 64'b01);
        check_mem("forced");
        check_static();
    endtask

    // Reset pulse then self-start; optional abort or busy-time en pulse (FILL cycle numbers).
    task automatic self_run(input int abort_at, input int pulse_at);
        int  k      = -1;
        int  done_n = -1;
        int  en_cnt = 0;
        bit  forced = 1'b0;
        @(negedge CLOCK_50);
        KEY[3] = 1'b0;
        @(negedge CLOCK_50);
        KEY[3] = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (forced) begin
                release dut.en;
                forced = 1'b0;
            end
            if (k >= 0 && pulse_at > 0 && n - k == pulse_at) begin
                force dut.en = 1'b1;
                forced = 1'b1;
            end
            if (dut.en) en_cnt++;
            if (k < 0 && LEDR[1]) k = n;
            if (abort_at > 0 && k >= 0 && n - k == abort_at) begin
                #3;
                KEY[3] = 1'b0;
                #1;
                check_eq("abort_wren", 64'(mon.wren), 64'd0);
                check_eq("abort_ledr", 64'(LEDR), 64'd0);
                return;
            end
            if (LEDR[0]) begin
                done_n = n;
                break;
            end
        end
        check_eq("self_start_edge", 64'(k), 64'd2);
        check_eq("self_done_edge", 64'(done_n), 64'd259);
        check_eq("en_high_cycles", 64'(en_cnt), 64'((pulse_at > 0) ? 2 : 1));
        check_mem("self");
        check_static();
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = byte_t'(i);

        KEY = 4'b0111;
        repeat ($urandom_range(1, 3)) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_eq("rst_ledr", 64'(LEDR), 64'd0);
        check_eq("rst_en", 64'(dut.en), 64'd0);
        check_eq("rst_wren", 64'(mon.wren), 64'd0);
        check_eq("rst_rdy", 64'(dut.rdy), 64'd1);
        check_static();

        forced_fill(1'b0, 1'b1);

        repeat ($urandom_range(1, 6)) @(negedge CLOCK_50);
        check_eq("done_hold", 64'(LEDR[1:0]), 64'b01);
        check_eq("no_restrobe", 64'(dut.en), 64'd0);

        forced_fill(1'b1, 1'b0);

        self_run(100, 0);
        self_run(0, 0);
        self_run($urandom_range(0, 1) ? 50 : 0, 0);
        self_run(0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arc4_task1.md
Name: arc4_task1

Overview:
- Top-level FPGA block for ARC4 step 1: after reset it fills a 256 x 8 state memory so that S[i] = i for i = 0..255.
- Contains:
  - a 256-word state RAM, instance name "s";
  - an init engine that walks addresses 0..255;
  - a small start controller that drives an internal one-cycle start strobe "en".
- Board I/O follows the DE1-SoC pin set. Later ARC4 tasks reuse the RAM and the rdy/en protocol.

Parameters:
- MEM_DEPTH, 256, number of state bytes; fixed for ARC4.
- DATA_W, 8, state byte width.

Ports:
- CLOCK_50  in   1   system clock; all logic on its rising edge.
- KEY       in   4   KEY[3] is the asynchronous active-low reset (rst_n); KEY[2:0] unused.
- SW        in   10  unused in this task; reserved for the key input in later tasks.
- HEX0..HEX5  out  7 each  seven-segment displays, active-low; all driven 7'b1111111 (blank).
- LEDR      out  10  LEDR[0] = init done; LEDR[1] = init busy; LEDR[9:2] = 0.

Behaviour:
- Reset (KEY[3]=0, asynchronous):
  - All FSMs go to their idle state, the counter goes to 0, and en, wren and LEDR go to 0.
  - RAM contents are not cleared.
- Internal strobe "en":
  - A single-bit logic net at top level, driving the init engine's start input.
  - The start controller raises en for exactly one cycle, on the first rising edge after reset deasserts while init rdy=1.
  - After that it holds en=0 until the next reset.
  - en must also accept an externally forced value: the init engine simply samples it.
- Init engine protocol (rdy/en):
  - rdy=1 in IDLE.
  - en sampled 1 at edge k while rdy=1: the engine enters FILL and drops rdy at that same edge.
  - en while rdy=0 is ignored.
- FILL state:
  - Drives addr=i, wrdata=i[7:0], wren=1.
  - Writes S[0] at edge k+1, S[1] at edge k+2, ..., S[255] at edge k+256.
  - i is 9 bits wide; FILL terminates after i=255 with no wrap to 0.
- After the last write:
  - wren=0 and the engine moves to DONE.
  - rdy=1 and LEDR[0]=1 from edge k+257 onward.
- A new en in DONE restarts FILL from i=0. The refill is idempotent and leaves identical contents.
- Reset mid-FILL aborts immediately. Partially written contents remain; the next start rewrites all 256 entries.
- State RAM (module s_mem, instance s):
  - 256 x 8, single port.
  - Synchronous write on wren.
  - Synchronous read with registered q, 1-cycle latency; read and write share the address.
  - Backing array is named mem_data and is hierarchically visible to benches.
  - Read/write to the same address in one cycle returns the old data.
- Top-level address and data mux is owned by init in this task: addr, wrdata and wren come straight from the init engine.

Decomposition:
- Package arc4_pkg:
  - MEM_DEPTH, DATA_W, ADDR_W=8;
  - typedef addr_t (logic [7:0]) and byte_t (logic [7:0]);
  - enum init_state_t {IDLE, FILL, DONE};
  - constant HEX_BLANK = 7'b1111111.
- Sub-modules:
  - init, the fill engine with ports clk, rst_n, en, rdy, addr, wrdata, wren;
  - s_mem, the RAM.
- The top holds the start controller and the LED/HEX drive.

Test Plan:
- Hold KEY[3]=0 for 1 cycle, then release; force en=1 for one cycle, then release -> rdy low next cycle. After 256 further cycles, mem_data[i]==i for all i = 0..255 (mem_data[0]=0, mem_data[128]=128, mem_data[255]=255), and LEDR[0]=1.
- No forcing, release reset -> the internal controller self-starts. After 258 cycles mem_data[i]==i everywhere and en was high exactly 1 cycle.
- Pulse en again while busy (cycle 50 of FILL) -> ignored; done still arrives at k+257 and contents are correct.
- Assert KEY[3]=0 at FILL cycle 100 -> wren=0 and LEDR=0 immediately (asynchronously). After release the controller re-strobes en, and the full 0..255 pattern is present 258 cycles later.
- Throughout -> HEX0..HEX5 == 7'b1111111 and LEDR[9:2]==0. With SW toggled arbitrarily, there is no effect on memory contents.
